// File: rtl/calculation_unit_result_collector.sv
// Two-channel result collector: merges the fast ADD/SUB/MUL path and the DIV/SQRT path into one
// ordered stream through a 2-entry output stage. Optional check logic: CALC_COLLECTOR_CHECK_EN.
package calculation;
  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    MUL  = 3'd2,
    DIV  = 3'd3,
    SQRT = 3'd4
  } calculation_select;
endpackage

module calculation_unit_result_collector #(
  parameter int FRACTION_WIDTH = 49,
  parameter int QR_WIDTH       = 26,
  parameter int TAG_WIDTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  calculation::calculation_select in_select,
  input  logic [TAG_WIDTH-1:0]          in_tag,
  input  logic [FRACTION_WIDTH-1:0]     fraction_adder,
  input  logic [FRACTION_WIDTH-1:0]     fraction_subtractor,
  input  logic [FRACTION_WIDTH-1:0]     fraction_multiplier,
  input  logic                          qr_valid,
  output logic                          qr_ready,
  input  calculation::calculation_select qr_select,
  input  logic [TAG_WIDTH-1:0]          qr_tag,
  input  logic [QR_WIDTH-1:0]           quotient_root,
  output logic                          out_valid,
  input  logic                          out_ready,
  output calculation::calculation_select out_select,
  output logic [TAG_WIDTH-1:0]          out_tag,
  output logic [FRACTION_WIDTH-1:0]     calculated_fraction
`ifdef CALC_COLLECTOR_CHECK_EN
  ,
  output logic                          protocol_error
`endif
);

  localparam int QR_SHIFT = FRACTION_WIDTH - 1 - QR_WIDTH;

  if (FRACTION_WIDTH < QR_WIDTH + 1) begin : g_width_check
    $error("FRACTION_WIDTH must be at least QR_WIDTH+1");
  end

  logic                          main_vld_q, main_vld_d;
  calculation::calculation_select main_sel_q, main_sel_d;
  logic [TAG_WIDTH-1:0]          main_tag_q, main_tag_d;
  logic [FRACTION_WIDTH-1:0]     main_frac_q, main_frac_d;
  logic                          skid_vld_q, skid_vld_d;
  calculation::calculation_select skid_sel_q, skid_sel_d;
  logic [TAG_WIDTH-1:0]          skid_tag_q, skid_tag_d;
  logic [FRACTION_WIDTH-1:0]     skid_frac_q, skid_frac_d;
  logic                          prio_qr_q, prio_qr_d;

  logic                          fast_fire, qr_fire, push, pop;
  logic [FRACTION_WIDTH-1:0]     fast_frac, qr_frac;
  calculation::calculation_select push_sel;
  logic [TAG_WIDTH-1:0]          push_tag;
  logic [FRACTION_WIDTH-1:0]     push_frac;

  // A collision always leaves exactly one channel ready, so the two fires are exclusive.
  assign in_ready  = ~skid_vld_q & (~qr_valid | ~prio_qr_q);
  assign qr_ready  = ~skid_vld_q & (~in_valid | prio_qr_q);
  assign fast_fire = in_valid & in_ready;
  assign qr_fire   = qr_valid & qr_ready;
  assign push      = fast_fire | qr_fire;
  assign pop       = main_vld_q & out_ready;

  // Quotient/root has one integer bit; the common format has two, so prepend a zero.
  assign qr_frac = FRACTION_WIDTH'(quotient_root) << QR_SHIFT;

  always_comb begin
    case (in_select)
      calculation::SUB: fast_frac = fraction_subtractor;
      calculation::MUL: fast_frac = fraction_multiplier;
      default:          fast_frac = fraction_adder;
    endcase
  end

  assign push_sel  = qr_fire ? qr_select : in_select;
  assign push_tag  = qr_fire ? qr_tag : in_tag;
  assign push_frac = qr_fire ? qr_frac : fast_frac;

  always_comb begin
    main_vld_d  = main_vld_q;
    main_sel_d  = main_sel_q;
    main_tag_d  = main_tag_q;
    main_frac_d = main_frac_q;
    skid_vld_d  = skid_vld_q;
    skid_sel_d  = skid_sel_q;
    skid_tag_d  = skid_tag_q;
    skid_frac_d = skid_frac_q;
    prio_qr_d   = prio_qr_q;
    if (in_valid && qr_valid && !skid_vld_q) begin
      prio_qr_d = ~prio_qr_q;
    end
    if (pop && skid_vld_q) begin
      // Skid full implies no push this cycle.
      main_sel_d  = skid_sel_q;
      main_tag_d  = skid_tag_q;
      main_frac_d = skid_frac_q;
      skid_vld_d  = 1'b0;
    end else if (push && (pop || !main_vld_q)) begin
      main_vld_d  = 1'b1;
      main_sel_d  = push_sel;
      main_tag_d  = push_tag;
      main_frac_d = push_frac;
    end else if (push) begin
      skid_vld_d  = 1'b1;
      skid_sel_d  = push_sel;
      skid_tag_d  = push_tag;
      skid_frac_d = push_frac;
    end else if (pop) begin
      main_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld_q  <= 1'b0;
      main_sel_q  <= calculation::ADD;
      main_tag_q  <= '0;
      main_frac_q <= '0;
      skid_vld_q  <= 1'b0;
      prio_qr_q   <= 1'b1;
    end else begin
      main_vld_q  <= main_vld_d;
      main_sel_q  <= main_sel_d;
      main_tag_q  <= main_tag_d;
      main_frac_q <= main_frac_d;
      skid_vld_q  <= skid_vld_d;
      prio_qr_q   <= prio_qr_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_sel_q  <= skid_sel_d;
    skid_tag_q  <= skid_tag_d;
    skid_frac_q <= skid_frac_d;
  end

  assign out_valid           = main_vld_q;
  assign out_select          = main_sel_q;
  assign out_tag             = main_tag_q;
  assign calculated_fraction = main_frac_q;

`ifdef CALC_COLLECTOR_CHECK_EN
  logic                  qr_hold_q;
  logic [TAG_WIDTH-1:0]  qr_tag_hold_q;
  logic [QR_WIDTH-1:0]   qr_data_hold_q;
  logic                  err_q;
  logic                  fast_bad, qr_bad, qr_unstable;

  assign fast_bad    = fast_fire & ((in_select == calculation::DIV) | (in_select == calculation::SQRT));
  assign qr_bad      = qr_fire & ~((qr_select == calculation::DIV) | (qr_select == calculation::SQRT));
  // A stalled qr request must stay asserted with unchanged tag and payload.
  assign qr_unstable = qr_hold_q & (~qr_valid | (qr_tag != qr_tag_hold_q) |
                                    (quotient_root != qr_data_hold_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      qr_hold_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      qr_hold_q <= qr_valid & ~qr_ready;
      if (fast_bad || qr_bad || qr_unstable) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    qr_tag_hold_q  <= qr_tag;
    qr_data_hold_q <= quotient_root;
  end

  assign protocol_error = err_q;
`endif

endmodule

// File: tb/tb_calculation_unit_result_collector.sv
// Bench for calculation_unit_result_collector: directed vector table, hand sequences for
// backpressure/reset, and a randomized run against a queue-based reference model.
module tb_calculation_unit_result_collector import calculation::*;;

  localparam int FW = 49;
  localparam int QW = 26;
  localparam int TW = 4;
  localparam calculation_select OTHER = calculation_select'(3'd7);

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready;
  calculation_select in_select;
  logic [TW-1:0]     in_tag;
  logic [FW-1:0]     fraction_adder, fraction_subtractor, fraction_multiplier;
  logic              qr_valid, qr_ready;
  calculation_select qr_select;
  logic [TW-1:0]     qr_tag;
  logic [QW-1:0]     quotient_root;
  logic              out_valid, out_ready;
  calculation_select out_select;
  logic [TW-1:0]     out_tag;
  logic [FW-1:0]     calculated_fraction;
`ifdef CALC_COLLECTOR_CHECK_EN
  logic              protocol_error;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calculation_unit_result_collector #(.FRACTION_WIDTH(FW), .QR_WIDTH(QW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_select(in_select), .in_tag(in_tag),
    .fraction_adder(fraction_adder), .fraction_subtractor(fraction_subtractor),
    .fraction_multiplier(fraction_multiplier),
    .qr_valid(qr_valid), .qr_ready(qr_ready), .qr_select(qr_select), .qr_tag(qr_tag),
    .quotient_root(quotient_root),
    .out_valid(out_valid), .out_ready(out_ready), .out_select(out_select), .out_tag(out_tag),
    .calculated_fraction(calculated_fraction)
`ifdef CALC_COLLECTOR_CHECK_EN
    , .protocol_error(protocol_error)
`endif
  );

  typedef struct {
    logic iv; calculation_select isel; logic [TW-1:0] itag;
    logic [FW-1:0] fa, fs, fm;
    logic qv; calculation_select qsel; logic [TW-1:0] qtag; logic [QW-1:0] qr;
    logic ordy;
    logic e_ir, e_qr, e_ov; calculation_select e_sel; logic [TW-1:0] e_tag; logic [FW-1:0] e_frac;
  } vec_t;

  typedef struct {
    calculation_select sel; logic [TW-1:0] tag; logic [FW-1:0] frac;
  } ent_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic iv, input calculation_select isel, input logic [TW-1:0] itag,
                              input logic [FW-1:0] fa, input logic [FW-1:0] fs, input logic [FW-1:0] fm,
                              input logic qv, input calculation_select qsel, input logic [TW-1:0] qtag,
                              input logic [QW-1:0] qr, input logic ordy,
                              input logic e_ir, input logic e_qr, input logic e_ov,
                              input calculation_select e_sel, input logic [TW-1:0] e_tag,
                              input logic [FW-1:0] e_frac);
    vec_t v;
    v.iv = iv; v.isel = isel; v.itag = itag; v.fa = fa; v.fs = fs; v.fm = fm;
    v.qv = qv; v.qsel = qsel; v.qtag = qtag; v.qr = qr; v.ordy = ordy;
    v.e_ir = e_ir; v.e_qr = e_qr; v.e_ov = e_ov; v.e_sel = e_sel; v.e_tag = e_tag; v.e_frac = e_frac;
    return v;
  endfunction

  task automatic idle_inputs();
    in_valid = 0; in_select = ADD; in_tag = '0;
    fraction_adder = '0; fraction_subtractor = '0; fraction_multiplier = '0;
    qr_valid = 0; qr_select = DIV; qr_tag = '0; quotient_root = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    tick();
    tick();
    reset = 0;
  endtask

  function automatic logic [FW-1:0] exp_qr_frac(input logic [QW-1:0] qr);
    // Value of the 1.x quotient expressed in the 2.x format: same number, more fraction bits.
    logic [FW-1:0] scale;
    scale = 1;
    for (int k = 0; k < FW - 1 - QW; k++) scale = scale * 2;
    return FW'(qr) * scale;
  endfunction

  vec_t tbl[11];
  ent_t mq[$];
  bit   mprio;

  initial begin
    idle_inputs();
    out_ready = 1;
    reset = 1;
    tick();
    tick();
    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_frac", 64'(calculated_fraction), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_sel", 64'(out_select), 64'(ADD));
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_qr_ready", 64'(qr_ready), 64'd1);
`ifdef CALC_COLLECTOR_CHECK_EN
    chk("rst_perr", 64'(protocol_error), 64'd0);
`endif
    reset = 0;

    // Directed table: collisions from reset, alignment, fast mux, drain.
    tbl[0]  = mk(1, ADD, 5, 10, 0, 0, 1, DIV, 6, 1, 1,  0, 1, 1, DIV, 6, 49'h400000);
    tbl[1]  = mk(1, ADD, 5, 10, 0, 0, 1, DIV, 6, 1, 1,  1, 0, 1, ADD, 5, 49'd10);
    tbl[2]  = mk(1, ADD, 5, 10, 0, 0, 1, DIV, 6, 1, 1,  0, 1, 1, DIV, 6, 49'h400000);
    tbl[3]  = mk(1, ADD, 5, 10, 0, 0, 1, DIV, 6, 1, 1,  1, 0, 1, ADD, 5, 49'd10);
    tbl[4]  = mk(0, ADD, 0, 0, 0, 0, 1, DIV, 6, 1, 1,  0, 1, 1, DIV, 6, 49'h400000);
    tbl[5]  = mk(0, ADD, 0, 0, 0, 0, 1, SQRT, 3, 26'h2000000, 1, 0, 1, 1, SQRT, 3, 49'h0_8000_0000_0000);
    tbl[6]  = mk(1, ADD, 1, 1, 2, 3, 0, DIV, 0, 0, 1,  1, 1, 1, ADD, 1, 49'd1);
    tbl[7]  = mk(1, SUB, 2, 1, 2, 3, 0, DIV, 0, 0, 1,  1, 1, 1, SUB, 2, 49'd2);
    tbl[8]  = mk(1, MUL, 3, 1, 2, 3, 0, DIV, 0, 0, 1,  1, 1, 1, MUL, 3, 49'd3);
    tbl[9]  = mk(1, OTHER, 4, 1, 2, 3, 0, DIV, 0, 0, 1, 1, 1, 1, OTHER, 4, 49'd1);
    tbl[10] = mk(0, ADD, 0, 0, 0, 0, 0, DIV, 0, 0, 1,  1, 1, 0, ADD, 0, 49'd0);
    for (int i = 0; i < 11; i++) begin
      in_valid = tbl[i].iv; in_select = tbl[i].isel; in_tag = tbl[i].itag;
      fraction_adder = tbl[i].fa; fraction_subtractor = tbl[i].fs; fraction_multiplier = tbl[i].fm;
      qr_valid = tbl[i].qv; qr_select = tbl[i].qsel; qr_tag = tbl[i].qtag; quotient_root = tbl[i].qr;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
      chk($sformatf("vec%0d_qr_ready", i), 64'(qr_ready), 64'(tbl[i].e_qr));
      tick();
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        chk($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(tbl[i].e_tag));
        chk($sformatf("vec%0d_sel", i), 64'(out_select), 64'(tbl[i].e_sel));
        chk($sformatf("vec%0d_frac", i), 64'(calculated_fraction), 64'(tbl[i].e_frac));
      end
    end

    // Backpressure: three fast ops with the output stalled.
    idle_inputs();
    out_ready = 0;
    fraction_adder = 101; in_select = ADD;
    in_valid = 1; in_tag = 1; #1;
    chk("bp1_in_ready", 64'(in_ready), 64'd1);
    tick();
    fraction_adder = 102; in_tag = 2; #1;
    chk("bp2_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("bp2_out_tag", 64'(out_tag), 64'd1);
    fraction_adder = 103; in_tag = 3; #1;
    chk("bp3_in_ready", 64'(in_ready), 64'd0);
    chk("bp3_qr_ready", 64'(qr_ready), 64'd0);
    tick();
    chk("bp3_hold_tag", 64'(out_tag), 64'd1);
    chk("bp3_hold_frac", 64'(calculated_fraction), 64'd101);
    out_ready = 1; #1;
    chk("bp4_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("bp4_out_tag", 64'(out_tag), 64'd2);
    chk("bp4_out_frac", 64'(calculated_fraction), 64'd102);
    chk("bp5_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("bp5_out_tag", 64'(out_tag), 64'd3);
    chk("bp5_out_frac", 64'(calculated_fraction), 64'd103);
    in_valid = 0;
    tick();
    chk("bp6_out_valid", 64'(out_valid), 64'd0);

    // Reset mid-operation with both entries occupied and prio_qr moved away from qr.
    out_ready = 0;
    in_valid = 1; in_tag = 8; fraction_adder = 55;
    qr_valid = 1; qr_tag = 9; qr_select = DIV; quotient_root = 5; #1;
    chk("rm_col_qr_ready", 64'(qr_ready), 64'd1);
    tick();
    qr_valid = 0; #1;
    chk("rm_fast_ready", 64'(in_ready), 64'd1);
    tick();
    chk("rm_full_ready", 64'(in_ready), 64'd0);
    reset = 1;
    idle_inputs();
    tick();
    reset = 0;
    chk("rm_out_valid", 64'(out_valid), 64'd0);
    chk("rm_frac", 64'(calculated_fraction), 64'd0);
    in_valid = 1; in_tag = 1; qr_valid = 1; qr_tag = 2; quotient_root = 3; #1;
    chk("rm_col_in_ready", 64'(in_ready), 64'd0);
    chk("rm_col_qr_ready2", 64'(qr_ready), 64'd1);
    tick();
    chk("rm_after_tag", 64'(out_tag), 64'd2);
    chk("rm_after_frac", 64'(calculated_fraction), 64'(exp_qr_frac(3)));
    out_ready = 1;
    idle_inputs();
    tick();
    tick();

`ifdef CALC_COLLECTOR_CHECK_EN
    do_reset();
    in_valid = 1; in_select = DIV; in_tag = 7;
    tick();
    in_valid = 0; in_select = ADD;
    chk("perr_set", 64'(protocol_error), 64'd1);
    tick();
    tick();
    chk("perr_sticky", 64'(protocol_error), 64'd1);
    do_reset();
    chk("perr_clear", 64'(protocol_error), 64'd0);
`endif

    // Randomized run against a queue model of the two-entry stage.
    do_reset();
    mq.delete();
    mprio = 1;
    begin
      bit qr_hold = 0;
      for (int n = 0; n < 3000; n++) begin
        bit full, e_ir, e_qr, ffire, qfire, pop;
        ent_t e;
        in_valid = ($urandom_range(0, 99) < 60);
        case ($urandom_range(0, 3))
          0: in_select = ADD;
          1: in_select = SUB;
          2: in_select = MUL;
          default: in_select = OTHER;
        endcase
        in_tag = TW'($urandom);
        fraction_adder = {17'($urandom), 32'($urandom)};
        fraction_subtractor = {17'($urandom), 32'($urandom)};
        fraction_multiplier = {17'($urandom), 32'($urandom)};
        if (!qr_hold) begin
          qr_valid = ($urandom_range(0, 99) < 50);
          qr_select = ($urandom_range(0, 1) == 0) ? DIV : SQRT;
          qr_tag = TW'($urandom);
          quotient_root = QW'($urandom);
        end
        out_ready = ($urandom_range(0, 99) < 65);
        #1;
        full = (mq.size() == 2);
        e_ir = !full && (!qr_valid || !mprio);
        e_qr = !full && (!in_valid || mprio);
        chk("rnd_in_ready", 64'(in_ready), 64'(e_ir));
        chk("rnd_qr_ready", 64'(qr_ready), 64'(e_qr));
        ffire = in_valid && e_ir;
        qfire = qr_valid && e_qr;
        if (in_valid && qr_valid && !full) mprio = !mprio;
        pop = (mq.size() > 0) && out_ready;
        qr_hold = qr_valid && !e_qr;
        if (ffire) begin
          e.sel = in_select; e.tag = in_tag;
          if (in_select == SUB) e.frac = fraction_subtractor;
          else if (in_select == MUL) e.frac = fraction_multiplier;
          else e.frac = fraction_adder;
        end else begin
          e.sel = qr_select; e.tag = qr_tag; e.frac = exp_qr_frac(quotient_root);
        end
        tick();
        if (pop) void'(mq.pop_front());
        if (ffire || qfire) mq.push_back(e);
        chk("rnd_out_valid", 64'(out_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
          chk("rnd_out_tag", 64'(out_tag), 64'(mq[0].tag));
          chk("rnd_out_sel", 64'(out_select), 64'(mq[0].sel));
          chk("rnd_out_frac", 64'(calculated_fraction), 64'(mq[0].frac));
        end
      end
    end
`ifdef CALC_COLLECTOR_CHECK_EN
    chk("rnd_no_perr", 64'(protocol_error), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
